// File: rtl/hdmi_pll_reset_sequencer.sv
// HDMI PLL reset sequencer: PLL reset pulse, lock wait with bounded retries, lock debounce,
// and staggered release of the pixel/aux domain resets. Optional HDMI_PLL_SEQ_STATS_EN builds the lock-loss counter.
module hdmi_pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned RST_STAGGER_CYCLES  = 8,
    parameter int unsigned RW                  = $clog2(MAX_RETRIES + 1)
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          restart_req,
    output logic          pll_rst,
    output logic          rst_out0,
    output logic          rst_out1,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_cnt,
    output logic [7:0]    lock_loss_cnt
);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_REL0      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > RST_STAGGER_CYCLES) ? LOCK_TIMEOUT_CYCLES : RST_STAGGER_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(RST_STAGGER_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_ONE    = RW'(1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

    logic          sync1_q;
    logic          lk_q;
    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [RW-1:0] retry_q,   retry_d;
    logic          pll_rst_q, pll_rst_d;
    logic          rst0_q,    rst0_d;
    logic          rst1_q,    rst1_d;
    logic          ready_q,   ready_d;
    logic          fault_q,   fault_d;
    logic          loss_event;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_q    <= sync1_q;
        end
    end

    // One shared counter; every transition reloads it so each state starts counting from a known value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        loss_event = 1'b0;
        if (restart_req) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_q) begin
                        // The cycle that saw lock already counts toward the debounce window.
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_d = ST_REL0;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_STABLE;
                            cnt_d   = CNT_ONE;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + RETRY_ONE;
                        cnt_d   = '0;
                        state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_PLL_RST;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lk_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_REL0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_REL0: begin
                    if (!lk_q) begin
                        state_d    = ST_PLL_RST;
                        cnt_d      = '0;
                        loss_event = 1'b1;
                    end else if (cnt_q == STAGGER_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    retry_d = '0;
                    if (!lk_q) begin
                        state_d    = ST_PLL_RST;
                        cnt_d      = '0;
                        loss_event = 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they change on the same edge as the state register.
    always_comb begin
        pll_rst_d = 1'b0;
        rst0_d    = 1'b1;
        rst1_d    = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            ST_PLL_RST: pll_rst_d = 1'b1;
            ST_REL0:    rst0_d    = 1'b0;
            ST_RUN: begin
                rst0_d  = 1'b0;
                rst1_d  = 1'b0;
                ready_d = 1'b1;
            end
            ST_FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: pll_rst_d = 1'b0;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst0_q    <= 1'b1;
            rst1_q    <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            rst0_q    <= rst0_d;
            rst1_q    <= rst1_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

`ifdef HDMI_PLL_SEQ_STATS_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else if (loss_event && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    logic loss_event_unused;

    assign loss_event_unused = loss_event;
    assign lock_loss_cnt     = 8'd0;
`endif

    assign pll_rst   = pll_rst_q;
    assign rst_out0  = rst0_q;
    assign rst_out1  = rst1_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule
